// File: rtl/e2prom_req_ctrl_if.sv
// -----------------------------------------------------------------------------
// e2prom_req_ctrl_if
// Request/handshake bundle between the key-driven EEPROM request controller
// and the I2C master.
//   i2c_start_flag  ctrl -> i2c  start request, level until start_done
//   i2c_wr_flag     ctrl -> i2c  write transfer, level until key_done
//   i2c_rd_flag     ctrl -> i2c  read transfer, level until key_done
//   i2c_addr        ctrl -> i2c  EEPROM word address
//   i2c_data_wr     ctrl -> i2c  write data
//   start_done      i2c -> ctrl  start accepted (1-cycle pulse)
//   key_done        i2c -> ctrl  transfer complete (1-cycle pulse)
//   i2c_data_rd     i2c -> ctrl  read data, valid with key_done of a read
// -----------------------------------------------------------------------------
interface e2prom_req_ctrl_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic              i2c_start_flag;
    logic              i2c_wr_flag;
    logic              i2c_rd_flag;
    logic [ADDR_W-1:0] i2c_addr;
    logic [DATA_W-1:0] i2c_data_wr;
    logic              start_done;
    logic              key_done;
    logic [DATA_W-1:0] i2c_data_rd;

    modport master (
        output i2c_start_flag, i2c_wr_flag, i2c_rd_flag, i2c_addr, i2c_data_wr,
        input  start_done, key_done, i2c_data_rd
    );

    modport slave (
        input  i2c_start_flag, i2c_wr_flag, i2c_rd_flag, i2c_addr, i2c_data_wr,
        output start_done, key_done, i2c_data_rd
    );
endinterface

// File: rtl/e2prom_req_ctrl.sv
// -----------------------------------------------------------------------------
// e2prom_req_ctrl
// Turns three debounced board keys (write, read, pointer-clear) into EEPROM
// request flags for the I2C master. A walking pointer selects the address
// inside a window of NUM_WORDS words starting at BASE_ADDR; every completed
// write bumps the write pattern. One press arriving during a transfer is
// parked in a pending slot; further presses are counted as dropped.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   key_wr/rd/clr    raw active-low keys, asynchronous to clk
//   i2c              request/handshake bundle (master side)
//   rd_data          last captured read value
//   rd_valid         1-cycle pulse when rd_data updates
//   busy             transfer in progress (state != IDLE)
//   drop_cnt         discarded presses, saturating at 255
// -----------------------------------------------------------------------------
module e2prom_req_ctrl #(
    parameter int unsigned       CNT_MAX   = 20'd999_999,
    parameter int unsigned       ADDR_W    = 16,
    parameter int unsigned       DATA_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       NUM_WORDS = 16,
    parameter logic [DATA_W-1:0] DATA_INIT = DATA_W'(123)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                key_wr,
    input  logic                key_rd,
    input  logic                key_clr,
    e2prom_req_ctrl_if.master   i2c,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                busy,
    output logic [7:0]          drop_cnt
);

    localparam int unsigned    CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned    PTR_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_HOLD = CNT_W'(CNT_MAX);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_WORDS - 1);

    localparam int KEY_WR  = 0;
    localparam int KEY_RD  = 1;
    localparam int KEY_CLR = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    typedef enum logic [1:0] {
        OP_WR,
        OP_RD,
        OP_CLR
    } op_t;

    // Saturating add for the drop counter (up to three drops per cycle).
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // Pointer advance with wrap inside the window.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    logic [2:0]       key_raw;
    logic [2:0]       key_meta_p0;
    logic [2:0]       key_sync_p1;
    logic [CNT_W-1:0] db_cnt [3];
    logic [2:0]       press;
    logic [1:0]       n_press;

    state_t            state, state_nxt;
    logic              pend_vld;
    op_t               pend_op;
    logic              op_rd;
    logic [PTR_W-1:0]  ptr;
    logic [DATA_W-1:0] pattern;

    logic              start_op;
    logic              start_rd;
    logic              do_clr;
    logic              xfer_done;
    logic              pend_take;
    logic              pend_store;
    op_t               pend_store_op;
    logic [1:0]        n_drop;

    assign key_raw = {key_clr, key_rd, key_wr};

    // ---- key synchroniser (2 flops) and per-key debounce -------------------
    // Keys idle high, so the sync flops reset to 1. The counter parks at
    // CNT_MAX after firing, so a held key yields a single press pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_meta_p0 <= '1;
            key_sync_p1 <= '1;
            press       <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            key_meta_p0 <= key_raw;
            key_sync_p1 <= key_meta_p0;
            for (int i = 0; i < 3; i++) begin
                press[i] <= !key_sync_p1[i] && (db_cnt[i] == CNT_FIRE);
                if (key_sync_p1[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] != CNT_HOLD) begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign n_press = 2'(press[KEY_WR]) + 2'(press[KEY_RD]) + 2'(press[KEY_CLR]);

    // ---- request FSM: state register ---------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- request FSM: next state and arbitration ---------------------------
    // Priority among same-cycle sources is pending > clr > wr > rd; every
    // press that loses is dropped. While busy, the highest-priority press
    // goes to the pending slot if it is free.
    always_comb begin
        state_nxt     = state;
        start_op      = 1'b0;
        start_rd      = 1'b0;
        do_clr        = 1'b0;
        xfer_done     = 1'b0;
        pend_take     = 1'b0;
        pend_store    = 1'b0;
        pend_store_op = OP_WR;
        n_drop        = '0;

        unique case (state)
            ST_IDLE: begin
                if (pend_vld) begin
                    pend_take = 1'b1;
                    n_drop    = n_press;
                    if (pend_op == OP_CLR) begin
                        do_clr = 1'b1;
                    end else begin
                        start_op  = 1'b1;
                        start_rd  = (pend_op == OP_RD);
                        state_nxt = ST_REQ;
                    end
                end else if (press[KEY_CLR]) begin
                    do_clr = 1'b1;
                    n_drop = n_press - 2'd1;
                end else if (press[KEY_WR]) begin
                    start_op  = 1'b1;
                    state_nxt = ST_REQ;
                    n_drop    = n_press - 2'd1;
                end else if (press[KEY_RD]) begin
                    start_op  = 1'b1;
                    start_rd  = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i2c.start_done) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i2c.key_done) begin
                    state_nxt = ST_IDLE;
                    xfer_done = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if ((state != ST_IDLE) && (n_press != 2'd0)) begin
            if (!pend_vld) begin
                pend_store    = 1'b1;
                pend_store_op = press[KEY_CLR] ? OP_CLR :
                                press[KEY_WR]  ? OP_WR  : OP_RD;
                n_drop        = n_press - 2'd1;
            end else begin
                n_drop        = n_press;
            end
        end
    end

    // ---- datapath: pending slot, pointer, pattern, read capture ------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_vld <= 1'b0;
            pend_op  <= OP_WR;
            op_rd    <= 1'b0;
            ptr      <= '0;
            pattern  <= DATA_INIT;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (pend_take) begin
                pend_vld <= 1'b0;
            end else if (pend_store) begin
                pend_vld <= 1'b1;
                pend_op  <= pend_store_op;
            end

            if (start_op) begin
                op_rd <= start_rd;
            end

            if (do_clr) begin
                ptr     <= '0;
                pattern <= DATA_INIT;
            end else if (xfer_done) begin
                ptr <= ptr_inc(ptr);
                if (!op_rd) begin
                    pattern <= pattern + 1'b1;
                end
            end

            rd_valid <= xfer_done && op_rd;
            if (xfer_done && op_rd) begin
                rd_data <= i2c.i2c_data_rd;
            end

            drop_cnt <= sat_add8(drop_cnt, n_drop);
        end
    end

    // ---- outputs -----------------------------------------------------------
    // Address and data come straight from ptr/pattern, which only change in
    // IDLE, so they are stable for the whole request.
    assign busy               = (state != ST_IDLE);
    assign i2c.i2c_start_flag = (state == ST_REQ);
    assign i2c.i2c_wr_flag    = busy && !op_rd;
    assign i2c.i2c_rd_flag    = busy && op_rd;
    assign i2c.i2c_addr       = BASE_ADDR + ADDR_W'(ptr);
    assign i2c.i2c_data_wr    = pattern;

endmodule

// File: tb/tb_e2prom_req_ctrl.sv
module tb_e2prom_req_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       key_wr = 1'b1;
    logic       key_rd = 1'b1;
    logic       key_clr = 1'b1;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic [7:0] drop_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int n_start = 0;
    int n_rdv   = 0;
    logic st_prev = 1'b0;

    e2prom_req_ctrl_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    e2prom_req_ctrl #(
        .CNT_MAX   (10),
        .ADDR_W    (16),
        .DATA_W    (8),
        .BASE_ADDR (16'h0100),
        .NUM_WORDS (4),
        .DATA_INIT (8'd123)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .key_wr   (key_wr),
        .key_rd   (key_rd),
        .key_clr  (key_clr),
        .i2c      (bus),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Count start-flag rising edges and rd_valid cycles, settled after each edge.
    always @(posedge clk) begin
        #1;
        if (bus.i2c_start_flag && !st_prev) n_start++;
        st_prev = bus.i2c_start_flag;
        if (rd_valid) n_rdv++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Hold the keys in mask (bit0 wr, bit1 rd, bit2 clr) low for n cycles.
    task automatic press_keys(input logic [2:0] mask, input int n);
        @(negedge clk);
        key_wr  = !mask[0];
        key_rd  = !mask[1];
        key_clr = !mask[2];
        repeat (n) @(negedge clk);
        key_wr  = 1'b1;
        key_rd  = 1'b1;
        key_clr = 1'b1;
    endtask

    task automatic pulse_sd();
        @(negedge clk);
        bus.start_done = 1'b1;
        @(negedge clk);
        bus.start_done = 1'b0;
    endtask

    task automatic pulse_kd(input logic [7:0] d);
        @(negedge clk);
        bus.key_done    = 1'b1;
        bus.i2c_data_rd = d;
        @(negedge clk);
        bus.key_done    = 1'b0;
    endtask

    // One complete transfer: press, check request, start_done, key_done.
    task automatic run_xfer(input string tag, input logic [2:0] mask, input int n,
                            input logic rd, input logic [15:0] a, input logic [7:0] d,
                            input logic [7:0] rdv);
        int s0;
        s0 = n_start;
        press_keys(mask, n);
        for (int i = 0; i < 40 && !bus.i2c_start_flag; i++) @(negedge clk);
        chk({tag, "_start"}, bus.i2c_start_flag, 1);
        chk({tag, "_type"}, {bus.i2c_wr_flag, bus.i2c_rd_flag}, rd ? 2'b01 : 2'b10);
        chk({tag, "_addr"}, bus.i2c_addr, a);
        if (!rd) chk({tag, "_data"}, bus.i2c_data_wr, d);
        repeat (3) @(negedge clk);
        pulse_sd();
        chk({tag, "_sd_clr"}, {bus.i2c_start_flag, bus.i2c_wr_flag, bus.i2c_rd_flag},
            rd ? 3'b001 : 3'b010);
        repeat (5) @(negedge clk);
        chk({tag, "_addr_hold"}, bus.i2c_addr, a);
        pulse_kd(rdv);
        chk({tag, "_done"}, {busy, bus.i2c_wr_flag, bus.i2c_rd_flag}, 3'b000);
        chk({tag, "_one_start"}, n_start - s0, 1);
    endtask

    initial begin
        int s0;
        int r0;
        bus.start_done  = 1'b0;
        bus.key_done    = 1'b0;
        bus.i2c_data_rd = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_flags", {bus.i2c_start_flag, bus.i2c_wr_flag, bus.i2c_rd_flag}, 3'b000);
        chk("rst_addr", bus.i2c_addr, 16'h0100);
        chk("rst_data", bus.i2c_data_wr, 8'd123);
        chk("rst_misc", {rd_data, rd_valid, busy, drop_cnt}, 18'h0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // First write: 20-cycle press
        run_xfer("wr0", 3'b001, 20, 1'b0, 16'h0100, 8'd123, 8'h00);
        chk("wr0_next_addr", bus.i2c_addr, 16'h0101);
        chk("wr0_next_data", bus.i2c_data_wr, 8'd124);

        // Three more writes wrap the pointer, then a read at the base
        run_xfer("wr1", 3'b001, 14, 1'b0, 16'h0101, 8'd124, 8'h00);
        run_xfer("wr2", 3'b001, 14, 1'b0, 16'h0102, 8'd125, 8'h00);
        run_xfer("wr3", 3'b001, 14, 1'b0, 16'h0103, 8'd126, 8'h00);
        chk("wrap_addr", bus.i2c_addr, 16'h0100);
        r0 = n_rdv;
        run_xfer("rd0", 3'b010, 14, 1'b1, 16'h0100, 8'd0, 8'hA5);
        chk("rd0_valid", rd_valid, 1);
        chk("rd0_data", rd_data, 8'hA5);
        @(negedge clk);
        chk("rd0_valid_off", rd_valid, 0);
        chk("rd0_one_pulse", n_rdv - r0, 1);
        chk("rd0_pattern_kept", bus.i2c_data_wr, 8'd127);
        chk("rd0_next_addr", bus.i2c_addr, 16'h0101);

        // Bounced key never produces a press
        s0 = n_start;
        press_keys(3'b001, 5);
        press_keys(3'b000, 2);
        press_keys(3'b001, 5);
        repeat (20) @(negedge clk);
        chk("bounce_busy", busy, 0);
        chk("bounce_no_start", n_start - s0, 0);

        // Key held 100 cycles gives one request
        run_xfer("hold", 3'b001, 100, 1'b0, 16'h0101, 8'd127, 8'h00);

        // Read then write pressed during an active write
        press_keys(3'b001, 14);
        chk("pend_wr_start", bus.i2c_start_flag, 1);
        chk("pend_wr_addr", bus.i2c_addr, 16'h0102);
        chk("pend_wr_data", bus.i2c_data_wr, 8'd128);
        pulse_sd();
        press_keys(3'b010, 14);
        press_keys(3'b001, 14);
        chk("pend_drop", drop_cnt, 1);
        chk("pend_busy", busy, 1);
        pulse_kd(8'h00);
        chk("pend_k1", {busy, bus.i2c_start_flag, bus.i2c_rd_flag}, 3'b000);
        chk("pend_k1_addr", bus.i2c_addr, 16'h0103);
        @(negedge clk);
        chk("pend_k2", {busy, bus.i2c_start_flag, bus.i2c_wr_flag, bus.i2c_rd_flag}, 4'b1101);
        chk("pend_k2_addr", bus.i2c_addr, 16'h0103);
        pulse_sd();
        repeat (2) @(negedge clk);
        pulse_kd(8'h3C);
        chk("pend_rd_valid", rd_valid, 1);
        chk("pend_rd_data", rd_data, 8'h3C);
        chk("pend_rd_addr", bus.i2c_addr, 16'h0100);
        repeat (3) @(negedge clk);
        chk("pend_idle", busy, 0);

        // Write and read pressed together: write wins, read dropped
        run_xfer("same", 3'b011, 14, 1'b0, 16'h0100, 8'd129, 8'h00);
        chk("same_drop", drop_cnt, 2);
        chk("same_addr", bus.i2c_addr, 16'h0101);
        chk("same_data", bus.i2c_data_wr, 8'd130);

        // Clear: pointer and pattern back to start, no request
        s0 = n_start;
        press_keys(3'b100, 14);
        repeat (3) @(negedge clk);
        chk("clr_addr", bus.i2c_addr, 16'h0100);
        chk("clr_data", bus.i2c_data_wr, 8'd123);
        chk("clr_busy", busy, 0);
        chk("clr_no_start", n_start - s0, 0);

        // Asynchronous reset while in WAIT
        press_keys(3'b001, 14);
        chk("arst_start", bus.i2c_start_flag, 1);
        pulse_sd();
        repeat (2) @(negedge clk);
        chk("arst_wait", {busy, bus.i2c_wr_flag}, 2'b11);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_flags", {busy, bus.i2c_start_flag, bus.i2c_wr_flag, bus.i2c_rd_flag}, 4'b0000);
        chk("arst_misc", {rd_data, rd_valid, drop_cnt}, 17'h0);
        chk("arst_addr", bus.i2c_addr, 16'h0100);
        chk("arst_data", bus.i2c_data_wr, 8'd123);
        @(negedge clk);
        rstn = 1'b1;
        r0 = n_rdv;
        pulse_kd(8'h77);
        repeat (2) @(negedge clk);
        chk("post_kd_busy", busy, 0);
        chk("post_kd_addr", bus.i2c_addr, 16'h0100);
        chk("post_kd_data", bus.i2c_data_wr, 8'd123);
        chk("post_kd_rd", {rd_data, rd_valid}, 9'h0);
        chk("post_kd_no_rdv", n_rdv - r0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
